// File: rtl/reset_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module  : reset_seq_pkg
// Brief   : Shared types and constants for the reset sequencer.
// Revision: 1.0 - initial release
// ============================================================================
package reset_seq_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_LOCK = 3'd0,
        ST_WAIT      = 3'd1,
        ST_ASSERT    = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_RUN       = 3'd4
    } seq_state_t;

    // Bit positions inside the sticky REASON register
    localparam int c_rsn_por  = 0;
    localparam int c_rsn_lock = 1;
    localparam int c_rsn_ext  = 2;
    localparam int c_rsn_ndm  = 3;
    localparam int c_rsn_sw   = 4;
    localparam int c_rsn_w    = 5;

    localparam logic c_addr_ctrl   = 1'b0;
    localparam logic c_addr_reason = 1'b1;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/reset_debouncer.sv
`default_nettype none
// ============================================================================
// Module  : reset_debouncer
// Brief   : 2-FF synchroniser plus stability counter for a slow async input.
// Revision: 1.0 - initial release
// ============================================================================
module reset_debouncer #(
    parameter int DEBOUNCE_CYC = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_din,
    output logic o_dout
);

    localparam int c_cnt_w = $clog2(DEBOUNCE_CYC + 1);

    logic               r_meta;
    logic               r_sync;
    logic               r_state;
    logic [c_cnt_w-1:0] r_cnt;

    assign o_dout = r_state;

    // Output follows the input only after it has differed for DEBOUNCE_CYC cycles in a row
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta  <= 1'b0;
            r_sync  <= 1'b0;
            r_state <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_meta <= i_din;
            r_sync <= r_meta;
            if (r_sync == r_state) begin
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_w'(DEBOUNCE_CYC - 1)) begin
                r_state <= r_sync;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : reset_sequencer
// Brief   : POR / event reset FSM driving NUM_DOMAINS staggered domain resets.
// Revision: 1.0 - initial release
// ============================================================================
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NUM_DOMAINS  = 4,
    parameter int DM_DOMAIN    = 0,
    parameter int POR_WAIT_CYC = 8,
    parameter int HOLD_CYC     = 8,
    parameter int STAGGER_CYC  = 4,
    parameter int DEBOUNCE_CYC = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   pll_locked_i,
    input  logic                   ext_reset_i,
    input  logic                   ndm_reset_i,
    output logic [NUM_DOMAINS-1:0] domain_reset_o,
    output logic                   por_completed_o,
    input  logic                   wb_adr,
    input  logic [31:0]            wb_dat_w,
    output logic [31:0]            wb_dat_r,
    input  logic [3:0]             wb_sel,
    input  logic                   wb_cyc,
    input  logic                   wb_stb,
    input  logic                   wb_we,
    output logic                   wb_ack,
    output logic                   wb_stall,
    output logic                   wb_err
);

    localparam int c_cnt_max = max3(POR_WAIT_CYC, HOLD_CYC, NUM_DOMAINS * STAGGER_CYC);
    localparam int c_cnt_w   = $clog2(c_cnt_max + 1);
    localparam logic [NUM_DOMAINS-1:0] c_all      = '1;
    localparam logic [NUM_DOMAINS-1:0] c_ndm_mask = ~(NUM_DOMAINS'(1) << DM_DOMAIN);

    seq_state_t             r_state;
    logic [c_cnt_w-1:0]     r_cnt;
    logic [NUM_DOMAINS-1:0] r_dom;
    logic [NUM_DOMAINS-1:0] r_mask;
    logic                   r_sw_mode;
    logic                   r_por_done;
    logic [c_rsn_w-1:0]     r_reason;
    logic                   r_lock_meta;
    logic                   r_lock_sync;
    logic                   r_ack;
    logic [31:0]            r_dat_r;

    logic                   w_ext_db;
    logic                   w_bus_req;
    logic                   w_ctrl_wr;
    logic                   w_rsn_wr;
    logic [NUM_DOMAINS-1:0] w_sw_mask;
    logic [NUM_DOMAINS-1:0] w_hw_mask;
    logic                   w_hw_req;
    logic                   w_sw_req;
    logic                   w_active;
    logic [c_cnt_w-1:0]     w_cnt_inc;
    logic [c_rsn_w-1:0]     w_evt;
    logic                   w_unused_bits;

    reset_debouncer #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_ext_debounce (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_din  (ext_reset_i),
        .o_dout (w_ext_db)
    );

    assign w_bus_req = wb_cyc & wb_stb;
    assign w_ctrl_wr = w_bus_req & wb_we & (wb_adr == c_addr_ctrl);
    assign w_rsn_wr  = w_bus_req & wb_we & (wb_adr == c_addr_reason);
    assign w_sw_mask = wb_dat_w[NUM_DOMAINS-1:0];
    assign w_hw_mask = (w_ext_db ? c_all : '0) | (ndm_reset_i ? c_ndm_mask : '0);
    assign w_hw_req  = w_ext_db | ndm_reset_i;
    assign w_sw_req  = w_ctrl_wr && (r_state == ST_RUN) && (|w_sw_mask);
    assign w_active  = r_lock_sync &&
                       ((r_state == ST_ASSERT) || (r_state == ST_RELEASE) || (r_state == ST_RUN));
    assign w_cnt_inc = (r_cnt == c_cnt_w'(c_cnt_max)) ? r_cnt : r_cnt + 1'b1;

    assign domain_reset_o  = r_dom;
    assign por_completed_o = r_por_done;
    assign wb_ack          = r_ack;
    assign wb_dat_r        = r_dat_r;
    assign wb_stall        = 1'b0;
    assign wb_err          = 1'b0;
    assign w_unused_bits   = ^{wb_sel, wb_dat_w};

    // Event sources only count once the sequence is live; lock loss counts from WAIT onwards
    always_comb begin
        w_evt = '0;
        if (!r_lock_sync && (r_state != ST_WAIT_LOCK)) begin
            w_evt[c_rsn_lock] = 1'b1;
        end else if (w_active) begin
            w_evt[c_rsn_ext] = w_ext_db;
            w_evt[c_rsn_ndm] = ndm_reset_i;
            w_evt[c_rsn_sw]  = w_sw_req;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock_meta <= 1'b0;
            r_lock_sync <= 1'b0;
        end else begin
            r_lock_meta <= pll_locked_i;
            r_lock_sync <= r_lock_meta;
        end
    end

    // A set event beats a simultaneous write-1-to-clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_reason <= c_rsn_w'(1) << c_rsn_por;
        end else if (w_rsn_wr) begin
            r_reason <= (r_reason & ~wb_dat_w[c_rsn_w-1:0]) | w_evt;
        end else begin
            r_reason <= r_reason | w_evt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ack   <= 1'b0;
            r_dat_r <= '0;
        end else begin
            r_ack <= w_bus_req;
            if (w_bus_req && !wb_we) begin
                r_dat_r <= (wb_adr == c_addr_ctrl) ? 32'(r_dom) : 32'(r_reason);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_WAIT_LOCK;
            r_cnt      <= '0;
            r_dom      <= c_all;
            r_mask     <= c_all;
            r_sw_mode  <= 1'b0;
            r_por_done <= 1'b0;
        end else if (!r_lock_sync) begin
            r_state   <= ST_WAIT_LOCK;
            r_cnt     <= '0;
            r_dom     <= c_all;
            r_mask    <= c_all;
            r_sw_mode <= 1'b0;
        end else begin
            case (r_state)
                ST_WAIT_LOCK: begin
                    r_dom   <= c_all;
                    r_cnt   <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    r_dom <= c_all;
                    if (r_cnt == c_cnt_w'(POR_WAIT_CYC - 1)) begin
                        r_state   <= ST_ASSERT;
                        r_cnt     <= '0;
                        r_mask    <= c_all;
                        r_sw_mode <= 1'b0;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                ST_ASSERT: begin
                    if (w_hw_req) begin
                        r_mask    <= r_mask | w_hw_mask;
                        r_dom     <= r_dom | w_hw_mask;
                        r_sw_mode <= 1'b0;
                        r_cnt     <= '0;
                    end else if (r_cnt == c_cnt_w'(HOLD_CYC - 1)) begin
                        r_cnt <= '0;
                        if (r_sw_mode) begin
                            r_dom   <= r_dom & ~r_mask;
                            r_state <= ST_RUN;
                        end else begin
                            r_state <= ST_RELEASE;
                        end
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                ST_RELEASE: begin
                    if (w_hw_req) begin
                        r_state   <= ST_ASSERT;
                        r_mask    <= w_hw_mask;
                        r_dom     <= r_dom | w_hw_mask;
                        r_sw_mode <= 1'b0;
                        r_cnt     <= '0;
                    end else begin
                        for (int k = 0; k < NUM_DOMAINS; k++) begin
                            if (r_cnt >= c_cnt_w'(k * STAGGER_CYC)) begin
                                r_dom[k] <= 1'b0;
                            end
                        end
                        if (r_cnt >= c_cnt_w'((NUM_DOMAINS - 1) * STAGGER_CYC)) begin
                            r_state    <= ST_RUN;
                            r_por_done <= 1'b1;
                            r_cnt      <= '0;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_hw_req || w_sw_req) begin
                        r_state   <= ST_ASSERT;
                        r_mask    <= w_hw_mask | (w_sw_req ? w_sw_mask : '0);
                        r_dom     <= r_dom | w_hw_mask | (w_sw_req ? w_sw_mask : '0);
                        r_sw_mode <= !w_hw_req;
                        r_cnt     <= '0;
                    end
                end
                default: begin
                    r_state <= ST_WAIT_LOCK;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reset_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_reset_sequencer
// Brief   : Directed self-checking bench for reset_sequencer.
// Revision: 1.0 - initial release
// ============================================================================
module tb_reset_sequencer;

    localparam int c_nd = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            pll_locked_i = 1'b0;
    logic            ext_reset_i = 1'b0;
    logic            ndm_reset_i = 1'b0;
    logic [c_nd-1:0] domain_reset_o;
    logic            por_completed_o;
    logic            wb_adr = 1'b0;
    logic [31:0]     wb_dat_w = '0;
    logic [31:0]     wb_dat_r;
    logic [3:0]      wb_sel = 4'hF;
    logic            wb_cyc = 1'b0;
    logic            wb_stb = 1'b0;
    logic            wb_we = 1'b0;
    logic            wb_ack;
    logic            wb_stall;
    logic            wb_err;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    reset_sequencer u_dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pll_locked_i    (pll_locked_i),
        .ext_reset_i     (ext_reset_i),
        .ndm_reset_i     (ndm_reset_i),
        .domain_reset_o  (domain_reset_o),
        .por_completed_o (por_completed_o),
        .wb_adr          (wb_adr),
        .wb_dat_w        (wb_dat_w),
        .wb_dat_r        (wb_dat_r),
        .wb_sel          (wb_sel),
        .wb_cyc          (wb_cyc),
        .wb_stb          (wb_stb),
        .wb_we           (wb_we),
        .wb_ack          (wb_ack),
        .wb_stall        (wb_stall),
        .wb_err          (wb_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wb_write(input string tag, input logic adr, input logic [31:0] d);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_adr = adr; wb_dat_w = d;
        step(1);
        check({tag, "_ack"}, 32'(wb_ack), 32'd1);
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; wb_dat_w = '0;
    endtask

    task automatic wb_read(input string tag, input logic adr, input logic [31:0] exp);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = adr;
        step(1);
        check({tag, "_ack"}, 32'(wb_ack), 32'd1);
        check(tag, wb_dat_r, exp);
        wb_cyc = 1'b0; wb_stb = 1'b0;
    endtask

    task automatic wait_d0_low(input string tag, input int limit);
        logic found;
        found = 1'b0;
        for (int i = 0; i < limit; i++) begin
            step(1);
            if (!domain_reset_o[0]) begin
                found = 1'b1;
                break;
            end
        end
        check({tag, "_d0_timeout"}, 32'(found), 32'd1);
    endtask

    // Called on the cycle domain 0 has just dropped; all four were asserted before
    task automatic check_stagger(input string tag);
        check({tag, "_d0"}, 32'(domain_reset_o), 32'hE);
        step(3);
        check({tag, "_d1_hold"}, 32'(domain_reset_o), 32'hE);
        step(1);
        check({tag, "_d1"}, 32'(domain_reset_o), 32'hC);
        step(4);
        check({tag, "_d2"}, 32'(domain_reset_o), 32'h8);
        step(4);
        check({tag, "_d3"}, 32'(domain_reset_o), 32'h0);
        check({tag, "_por"}, 32'(por_completed_o), 32'd1);
    endtask

    initial begin
        int n;
        logic found;

        // 1: power-on sequence
        step(3);
        check("rst_dom", 32'(domain_reset_o), 32'hF);
        check("rst_por", 32'(por_completed_o), 32'd0);
        check("rst_ack", 32'(wb_ack), 32'd0);
        check("stall_err", {30'd0, wb_stall, wb_err}, 32'd0);
        rst_n = 1'b1;
        step(10);
        pll_locked_i = 1'b1;
        check("prelock_dom", 32'(domain_reset_o), 32'hF);
        step(10);
        check("wait_dom", 32'(domain_reset_o), 32'hF);
        wait_d0_low("por", 60);
        check("por_early", 32'(por_completed_o), 32'd0);
        check_stagger("por");
        wb_read("rsn_por", 1'b1, 32'h01);

        // 2: external button, short glitch then long press
        ext_reset_i = 1'b1;
        step(5);
        ext_reset_i = 1'b0;
        step(30);
        check("ext_glitch", 32'(domain_reset_o), 32'h0);
        ext_reset_i = 1'b1;
        n = 0;
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step(1);
            n++;
            if (domain_reset_o != '0) begin
                found = 1'b1;
                break;
            end
        end
        check("ext_assert_timeout", 32'(found), 32'd1);
        check("ext_dom", 32'(domain_reset_o), 32'hF);
        step(40 - n);
        ext_reset_i = 1'b0;
        wait_d0_low("ext", 100);
        check_stagger("ext");
        wb_read("rsn_ext", 1'b1, 32'h05);
        wb_write("rsn_clr", 1'b1, 32'h1F);
        wb_read("rsn_zero", 1'b1, 32'h00);

        // 3: ndm request spares the debug domain
        ndm_reset_i = 1'b1;
        step(1);
        check("ndm_dom", 32'(domain_reset_o), 32'hE);
        step(2);
        ndm_reset_i = 1'b0;
        step(7);
        check("ndm_hold", 32'(domain_reset_o), 32'hE);
        step(6);
        check("ndm_d1", 32'(domain_reset_o), 32'hC);
        step(8);
        check("ndm_done", 32'(domain_reset_o), 32'h0);
        wb_read("rsn_ndm", 1'b1, 32'h08);

        // 4: software reset of domains 1 and 2
        wb_write("sw_wr", 1'b0, 32'h6);
        check("sw_dom", 32'(domain_reset_o), 32'h6);
        wb_read("sw_ctrl", 1'b0, 32'h6);
        step(6);
        check("sw_hold", 32'(domain_reset_o), 32'h6);
        step(1);
        check("sw_release", 32'(domain_reset_o), 32'h0);
        wb_read("rsn_sw", 1'b1, 32'h18);

        // 5: PLL lock loss mid-release
        ndm_reset_i = 1'b1;
        step(1);
        ndm_reset_i = 1'b0;
        step(9);
        check("rel_mid", 32'(domain_reset_o), 32'hE);
        pll_locked_i = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            if (domain_reset_o == 4'hF) begin
                found = 1'b1;
                break;
            end
        end
        check("lockloss_3cyc", 32'(found), 32'd1);
        wb_write("sw_drop", 1'b0, 32'h1);
        check("sw_drop_dom", 32'(domain_reset_o), 32'hF);
        wb_read("rsn_lock", 1'b1, 32'h1A);
        pll_locked_i = 1'b1;
        wait_d0_low("relock", 60);
        check_stagger("relock");

        // 6: clear racing an event, then rst_n mid-release
        ndm_reset_i = 1'b1;
        wb_write("rsn_race_wr", 1'b1, 32'h1F);
        ndm_reset_i = 1'b0;
        wb_read("rsn_race", 1'b1, 32'h08);
        step(8);
        check("rel_mid2", 32'(domain_reset_o), 32'hE);
        rst_n = 1'b0;
        #1;
        check("arst_dom", 32'(domain_reset_o), 32'hF);
        check("arst_por", 32'(por_completed_o), 32'd0);
        check("arst_ack", 32'(wb_ack), 32'd0);
        step(2);
        rst_n = 1'b1;
        wb_read("rsn_after_rst", 1'b1, 32'h01);
        check("after_rst_dom", 32'(domain_reset_o), 32'hF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
